// File: rtl/mixer_rr.sv
// Round-robin N-port packet mixer: merges FWFT input FIFOs into one output FIFO,
// moving each packet whole and forcing EOP after MAX_PKT words without one.
module mixer_rr #(
  parameter int NUM_PORTS  = 6,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 2048
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst_n,
  input  logic [NUM_PORTS*(DATA_WIDTH+1)-1:0] in_dout,
  input  logic [NUM_PORTS-1:0]                in_empty,
  output logic [NUM_PORTS-1:0]                in_rd_en,
  input  logic [NUM_PORTS-1:0]                port_mask,
  output logic [DATA_WIDTH:0]                 din,
  input  logic                                full,
  output logic                                wr_en,
  output logic [$clog2(NUM_PORTS)-1:0]        grant,
  output logic                                busy,
  output logic                                trunc_err
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_PKT);
  localparam int WW = DATA_WIDTH + 1;

  typedef enum logic {S_IDLE, S_XFER} state_e;

  state_e          state_q;
  logic [GW-1:0]   rr_q;
  logic [GW-1:0]   grant_q;
  logic [CW-1:0]   cnt_q;
  logic [WW-1:0]   din_q;
  logic            wr_en_q;
  logic            trunc_q;

  logic [WW-1:0]        port_word [NUM_PORTS];
  logic [WW-1:0]        cur_word;
  logic [NUM_PORTS-1:0] eligible;
  logic                 hit;
  logic [GW-1:0]        hit_idx;
  logic [GW-1:0]        scan_idx;
  logic                 pop;
  logic                 wdog_hit;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_word
    assign port_word[g] = in_dout[g*WW +: WW];
  end

  assign cur_word = port_word[grant_q];
  assign eligible = ~in_empty & port_mask;

  // Scan starts one past the last winner so every port gets a fair turn.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_idx = GW'((int'(rr_q) + k) % NUM_PORTS);
      if (!hit && eligible[scan_idx]) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  assign pop      = (state_q == S_XFER) && !in_empty[grant_q] && !full;
  assign wdog_hit = (cnt_q == CW'(MAX_PKT - 1));

  always_comb begin
    in_rd_en          = '0;
    in_rd_en[grant_q] = pop;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= GW'(NUM_PORTS - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      wr_en_q <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      wr_en_q <= 1'b0;
      trunc_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            grant_q <= hit_idx;
            rr_q    <= hit_idx;
            cnt_q   <= '0;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (pop) begin
            wr_en_q <= 1'b1;
            din_q   <= cur_word;
            if (cur_word[DATA_WIDTH]) begin
              state_q <= S_IDLE;
            end else if (wdog_hit) begin
              // Overlong packet: terminate it here; the rest becomes a new packet.
              din_q[DATA_WIDTH] <= 1'b1;
              trunc_q           <= 1'b1;
              state_q           <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign din       = din_q;
  assign wr_en     = wr_en_q;
  assign grant     = grant_q;
  assign busy      = (state_q == S_XFER);
  assign trunc_err = trunc_q;

endmodule

// File: tb/tb_mixer_rr.sv
// Scoreboard bench for mixer_rr: FIFO models feed the ports, expected words are queued
// at stimulus time and a negedge monitor compares every output write against them.
module tb_mixer_rr;

  localparam int NP = 6;
  localparam int DW = 8;
  localparam int WW = DW + 1;
  localparam int MP = 16;

  typedef logic [WW-1:0] word_t;
  typedef struct packed {
    logic [2:0] port;
    word_t      word;
    logic       trunc;
  } exp_t;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [NP*WW-1:0]  in_dout;
  logic [NP-1:0]     in_empty;
  logic [NP-1:0]     in_rd_en;
  logic [NP-1:0]     port_mask;
  logic [WW-1:0]     din;
  logic              full;
  logic              wr_en;
  logic [2:0]        grant;
  logic              busy;
  logic              trunc_err;

  word_t         fifo_q [NP][$];
  exp_t          exp_q[$];
  int            wr_log[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            trunc_cnt = 0;
  bit            mon_en = 1'b1;
  logic          full_last = 1'b0;
  logic [NP-1:0] last_pops;

  mixer_rr #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_PKT(MP)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .port_mask (port_mask),
    .din       (din),
    .full      (full),
    .wr_en     (wr_en),
    .grant     (grant),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      in_empty[i]         = (fifo_q[i].size() == 0);
      in_dout[i*WW +: WW] = (fifo_q[i].size() == 0) ? '0 : fifo_q[i][0];
    end
  endtask

  // One clock: sample pops before the edge, apply them at the edge, present new heads.
  task automatic tick();
    @(negedge sys_clk);
    last_pops = in_rd_en;
    @(posedge sys_clk);
    for (int i = 0; i < NP; i++)
      if (last_pops[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
    #1;
    refresh();
  endtask

  task automatic add_pkt(input int p, input int n, input logic [7:0] base);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w = {(k == n - 1), 8'(base + 8'(k))};
      fifo_q[p].push_back(w);
      exp_q.push_back('{port: 3'(p), word: w, trunc: 1'b0});
    end
  endtask

  task automatic flush_fifos();
    for (int i = 0; i < NP; i++) fifo_q[i].delete();
    refresh();
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({nm, "_drain"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (2) tick();
  endtask

  task automatic wait_writes(input string nm, input int target, input int budget);
    int n = 0;
    while (wr_log.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(nm, 32'(wr_log.size() >= target), 1);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    flush_fifos();
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    cyc++;
    if (sys_rst_n) begin
      if (full_last) check("wr_after_full", 32'(wr_en), 0);
      if (full) check("rd_while_full", 32'(in_rd_en), 0);
      if (trunc_err) trunc_cnt++;
      if (wr_en) begin
        wr_log.push_back(cyc);
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_write: got din 0x%0h, expected no write", din);
          end else begin
            e = exp_q.pop_front();
            check("din", 32'(din), 32'(e.word));
            check("grant", 32'(grant), 32'(e.port));
            check("trunc_err", 32'(trunc_err), 32'(e.trunc));
          end
        end
      end else if (trunc_err) begin
        check("trunc_without_wr", 32'(trunc_err), 0);
      end
    end
    full_last = full;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int c_a;
    int first;
    logic [NP-1:0] pops_or;
    word_t w;

    sys_rst_n = 1'b0;
    full      = 1'b0;
    port_mask = '0;
    flush_fifos();
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_rd_en", 32'(in_rd_en), 0);
    check("rst_din", 32'(din), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_trunc", 32'(trunc_err), 0);
    port_mask = '1;
    sys_rst_n = 1'b1;
    tick();

    // Two 4-word packets: port 0 whole, one idle cycle, then port 3.
    base = wr_log.size();
    add_pkt(0, 4, 8'h01);
    add_pkt(3, 4, 8'h31);
    refresh();
    wait_drain("t1", 60);
    check("t1_writes", 32'(wr_log.size() - base), 8);
    if (wr_log.size() >= base + 8) begin
      check("t1_gap_in_pkt", 32'(wr_log[base+1] - wr_log[base]), 1);
      check("t1_gap_idle", 32'(wr_log[base+4] - wr_log[base+3]), 2);
      check("t1_gap_pkt2", 32'(wr_log[base+7] - wr_log[base+4]), 3);
    end

    // All ports loaded with 1-word packets: grants 0..5 then 0..5 again.
    do_reset();
    base = wr_log.size();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) add_pkt(p, 1, 8'(p * 16 + r));
    refresh();
    wait_drain("t2", 100);
    check("t2_writes", 32'(wr_log.size() - base), 12);
    if (wr_log.size() >= base + 12)
      for (int j = 1; j < 12; j++) check("t2_gap", 32'(wr_log[base+j] - wr_log[base+j-1]), 2);

    // full held for 5 cycles mid-packet.
    base = wr_log.size();
    add_pkt(2, 6, 8'h21);
    refresh();
    wait_writes("t3_start", base + 2, 20);
    c_a  = cyc + 1;
    full = 1'b1;
    repeat (5) begin
      tick();
      check("t3_rd_stall", 32'(last_pops), 0);
    end
    full = 1'b0;
    wait_drain("t3", 40);
    check("t3_writes", 32'(wr_log.size() - base), 6);
    first = -1;
    for (int j = base; j < wr_log.size(); j++)
      if (first < 0 && wr_log[j] > c_a) first = wr_log[j];
    check("t3_resume", 32'(first), 32'(c_a + 6));

    // 20-word stream, EOP only on word 20: word 16 truncated, 17..20 a new packet.
    trunc_cnt = 0;
    base = wr_log.size();
    for (int k = 1; k <= 20; k++) begin
      w = {(k == 20), 8'(8'h40 + k)};
      fifo_q[1].push_back(w);
      exp_q.push_back('{port: 3'd1, word: (k == 16) ? {1'b1, w[7:0]} : w, trunc: (k == 16)});
    end
    refresh();
    wait_drain("t4", 120);
    check("t4_writes", 32'(wr_log.size() - base), 20);
    check("t4_trunc_pulses", 32'(trunc_cnt), 1);
    if (wr_log.size() >= base + 20)
      check("t4_regrant_gap", 32'(wr_log[base+16] - wr_log[base+15]), 2);

    // Mask lets only port 1 in; unmasking port 0 mid-packet waits for EOP.
    port_mask = 6'b000010;
    base = wr_log.size();
    add_pkt(1, 3, 8'h1A);
    add_pkt(0, 3, 8'h0A);
    refresh();
    wait_writes("t5_start", base + 1, 20);
    port_mask = 6'b000011;
    wait_drain("t5", 60);
    check("t5_writes", 32'(wr_log.size() - base), 6);

    // No eligible port: nothing moves.
    port_mask = '0;
    for (int k = 0; k < 6; k++) fifo_q[3].push_back({(k == 5), 8'(8'h60 + k)});
    refresh();
    base = wr_log.size();
    pops_or = '0;
    repeat (6) begin
      tick();
      pops_or |= last_pops;
    end
    check("idle_busy", 32'(busy), 0);
    check("idle_pops", 32'(pops_or), 0);
    check("idle_writes", 32'(wr_log.size() - base), 0);

    // Asynchronous reset mid-transfer, then arbitration restarts from port 0.
    mon_en    = 1'b0;
    port_mask = '1;
    wait_writes("t6_start", base + 1, 20);
    check("t6_busy_pre", 32'(busy), 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("t6_wr_en", 32'(wr_en), 0);
    check("t6_rd_en", 32'(in_rd_en), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_grant", 32'(grant), 0);
    check("t6_din", 32'(din), 0);
    flush_fifos();
    repeat (2) tick();
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    exp_q.delete();
    add_pkt(0, 1, 8'hF0);
    add_pkt(5, 1, 8'hF5);
    refresh();
    wait_drain("t6", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
